tx_dc_offset_insert: RTL

TX_DC_OFFSET_INSERT -- requirements
Module: tx_dc_offset_insert

---
 rtl/tx_dc_pkg.sv | 19 +
 rtl/dc_ramp_step.sv | 47 ++++
 rtl/tx_dc_offset_insert.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/tx_dc_pkg.sv
// ----------------------------------------------------------------------------
// tx_dc_pkg
// Shared definitions for the TX DC-offset (carrier-null) insertion block:
// default widths, the default ramp step and the ramp state enumeration.
// ----------------------------------------------------------------------------
package tx_dc_pkg;

   localparam int DW_DEF   = 24;  // I/Q sample width (signed)
   localparam int OW_DEF   = 16;  // offset word width (signed)
   localparam int STEP_DEF = 16;  // ramp increment, LSBs per accepted sample

   // IDLE : applied offset equals the target
   // RAMP : applied offset is still walking toward the target
   typedef enum logic {
      IDLE = 1'b0,
      RAMP = 1'b1
   } ramp_state_e;

endpackage

// File: rtl/dc_ramp_step.sv
// ----------------------------------------------------------------------------
// dc_ramp_step
// One channel of the offset ramp. When en is high the applied offset moves
// STEP LSBs toward the target, landing exactly on the target instead of
// overshooting it. When en is low the offset is returned unchanged.
// STEP is assumed to be below 2^OW.
//
// Ports
//   en   in   advance this cycle
//   cur  in   present applied offset (signed, OW)
//   tgt  in   target offset (signed, OW)
//   nxt  out  applied offset for the next cycle (signed, OW)
// ----------------------------------------------------------------------------
module dc_ramp_step
   import tx_dc_pkg::*;
#(
   parameter int OW   = OW_DEF,
   parameter int STEP = STEP_DEF
) (
   input  logic                 en,
   input  logic signed [OW-1:0] cur,
   input  logic signed [OW-1:0] tgt,
   output logic signed [OW-1:0] nxt
);

   // Two guard bits: the difference of two OW-bit signed values needs OW+1,
   // and cur +/- STEP is formed before narrowing back.
   localparam logic signed [OW+1:0] STEP_W = (OW+2)'(STEP);

   logic signed [OW+1:0] diff;

   always_comb begin
      diff = (OW+2)'(tgt) - (OW+2)'(cur);
      nxt  = cur;
      if (en) begin
         if (diff > STEP_W) begin
            nxt = OW'((OW+2)'(cur) + STEP_W);
         end else if (diff < -STEP_W) begin
            nxt = OW'((OW+2)'(cur) - STEP_W);
         end else begin
            // Within one step of the target: land on it exactly.
            nxt = tgt;
         end
      end
   end

endmodule

// File: rtl/tx_dc_offset_insert.sv
// ----------------------------------------------------------------------------
// tx_dc_offset_insert
// Adds a programmable DC offset to each TX I/Q sample so the DAC's carrier
// leakage can be nulled. A new offset target is loaded with offset_load; the
// applied offset then ramps toward it by STEP LSBs per accepted sample, so
// the carrier level never jumps. The ramp only advances on accepted samples.
//
// Configuration macro: TX_DC_SAT_EN
//   defined   : the I/Q + offset sum saturates to the DW-bit signed range
//   undefined : the sum wraps (two's-complement truncation to DW bits)
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     input sample handshake
//   in_i, in_q            input samples (signed, DW)
//   out_valid/out_ready   output sample handshake
//   out_i, out_q          offset-corrected samples (signed, DW), 1-cycle latency
//   offset_i, offset_q    new target offsets (signed, OW)
//   offset_load           capture offset_i/offset_q as the new target
//   ramp_busy             ramp FSM state: 1 = RAMP (applied != target)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready = !out_valid | out_ready, so the single output register
// accepts whenever it is empty or being drained; while out_valid=1 and
// out_ready=0 the output register holds its contents unchanged.
// ----------------------------------------------------------------------------
module tx_dc_offset_insert
   import tx_dc_pkg::*;
#(
   parameter int DW   = DW_DEF,
   parameter int OW   = OW_DEF,
   parameter int STEP = STEP_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_i,
   input  logic [DW-1:0] in_q,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_i,
   output logic [DW-1:0] out_q,
   input  logic [OW-1:0] offset_i,
   input  logic [OW-1:0] offset_q,
   input  logic          offset_load,
   output logic          ramp_busy
);

   ramp_state_e          state, state_nxt;
   logic signed [OW-1:0] cur_i, cur_q;
   logic signed [OW-1:0] tgt_i, tgt_q;
   logic signed [OW-1:0] nxt_i, nxt_q;
   logic signed [OW-1:0] tgt_nxt_i, tgt_nxt_q;
   logic                 accept;
   logic                 step_en;
   logic [DW-1:0]        res_i, res_q;

   assign in_ready  = !out_valid | out_ready;
   assign accept    = in_valid & in_ready;
   assign step_en   = accept & (state == RAMP);
   assign ramp_busy = (state == RAMP);

   // A load takes effect as the target from the next cycle; a sample accepted
   // in the same cycle still steps toward the old target.
   assign tgt_nxt_i = offset_load ? offset_i : tgt_i;
   assign tgt_nxt_q = offset_load ? offset_q : tgt_q;

   dc_ramp_step #(.OW(OW), .STEP(STEP)) u_step_i (
      .en  (step_en),
      .cur (cur_i),
      .tgt (tgt_i),
      .nxt (nxt_i)
   );

   dc_ramp_step #(.OW(OW), .STEP(STEP)) u_step_q (
      .en  (step_en),
      .cur (cur_q),
      .tgt (tgt_q),
      .nxt (nxt_q)
   );

   // ------------------------------------------------------------------------
   // Ramp FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            // cur does not move in IDLE, so only a differing load starts a ramp.
            if (offset_load && ((offset_i != cur_i) || (offset_q != cur_q))) begin
               state_nxt = RAMP;
            end
         end
         RAMP: begin
            // Compare next-cycle values so a retarget onto the landing point
            // (or the final step) ends the ramp on the same edge.
            if ((nxt_i == tgt_nxt_i) && (nxt_q == tgt_nxt_q)) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Offset registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_i <= '0;
         cur_q <= '0;
         tgt_i <= '0;
         tgt_q <= '0;
      end else begin
         cur_i <= nxt_i;
         cur_q <= nxt_q;
         tgt_i <= tgt_nxt_i;
         tgt_q <= tgt_nxt_q;
      end
   end

   // ------------------------------------------------------------------------
   // Offset insertion: sample + sign-extended pre-step offset
   // ------------------------------------------------------------------------
`ifdef TX_DC_SAT_EN
   logic signed [DW:0] sum_i, sum_q;

   function automatic logic [DW-1:0] sat_dw(input logic signed [DW:0] s);
      logic [DW-1:0] r;
      if (s[DW] != s[DW-1]) begin
         // Sign bit disagrees with MSB: overflowed, clip to the rail.
         r = s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end else begin
         r = s[DW-1:0];
      end
      return r;
   endfunction

   assign sum_i = (DW+1)'($signed(in_i)) + (DW+1)'(cur_i);
   assign sum_q = (DW+1)'($signed(in_q)) + (DW+1)'(cur_q);
   assign res_i = sat_dw(sum_i);
   assign res_q = sat_dw(sum_q);
`else
   // Low DW bits of the DW+1-bit sum are the DW-bit wrapped sum.
   assign res_i = in_i + DW'(cur_i);
   assign res_q = in_q + DW'(cur_q);
`endif

   // ------------------------------------------------------------------------
   // Output register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_i     <= '0;
         out_q     <= '0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_i <= res_i;
            out_q <= res_q;
         end
      end
   end

endmodule
